nco_sweep_controller: RTL and testbench
=======================================

NCO_SWEEP_CONTROLLER -- requirements
Module: nco_sweep_controller

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 64: width of the phase increment, start value and step.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16: width of the step count and the step index.
REQ-003 SHALL have parameter DWELL_WIDTH, default 16: width of the per-step dwell, in samples.
REQ-004 SHALL have parameter CE_DIV_WIDTH, default 8: width of the sample-strobe divider.
REQ-005 SHALL use reset arst, asynchronous, active-high, and clock clk.
REQ-006 SHALL have port clk, input, 1 bit: system clock.
REQ-007 SHALL have port arst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port ce_div, input, CE_DIV_WIDTH bits: a sample strobe is issued every ce_div+1 clocks.
REQ-009 SHALL have port cfg_valid, input, 1 bit: a configuration is offered.
REQ-010 SHALL have port cfg_ready, output, 1 bit: a configuration can be accepted.
REQ-011 SHALL have port cfg_start_inc, input, PHASE_WIDTH bits: first phase increment of the sweep.
REQ-012 SHALL have port cfg_step, input, PHASE_WIDTH bits: per-step delta, two's complement.
REQ-013 SHALL have port cfg_num_steps, input, COUNT_WIDTH bits: number of steps after the first tone.
REQ-014 SHALL have port cfg_dwell, input, DWELL_WIDTH bits: samples held per step, where 0 means 1.
REQ-015 SHALL have port cfg_loop, input, 1 bit: restart the sweep instead of finishing.
REQ-016 SHALL have port start, input, 1 bit: begin the sweep.
REQ-017 SHALL have port abort, input, 1 bit: stop the sweep immediately.
REQ-018 SHALL have port sample_clk_ce, output, 1 bit: one-clk sample strobe driven to the NCO.
REQ-019 SHALL have port phase_increment, output, PHASE_WIDTH bits: registered tuning word driven to the NCO.
REQ-020 SHALL have port busy, output, 1 bit: high while the state is DWELL.
REQ-021 SHALL have port done, output, 1 bit: one-clk pulse at the end of a non-looping sweep.
REQ-022 SHALL have port step_index, output, COUNT_WIDTH bits: index of the current step.

Function
REQ-023 SHALL run a free-running divider counter, independent of state, that pulses sample_clk_ce for one clk when the count equals ce_div and then wraps the count to 0; ce_div=0 SHALL give sample_clk_ce high on every clk.
REQ-024 SHALL drive cfg_ready high in IDLE and DONE and low in DWELL.
REQ-025 SHALL latch all cfg_* inputs into shadow registers on cfg_valid&cfg_ready; an offer made during DWELL SHALL be ignored.
REQ-026 SHALL implement the state set IDLE, DWELL, DONE.
REQ-027 SHALL, on start in IDLE or DONE, load phase_increment with the shadow start_inc, clear step_index and the dwell count, and enter DWELL on the next clk.
REQ-028 SHALL, when a config transfer and start occur in the same clk, use the newly transferred values.
REQ-029 SHALL, in DWELL, change nothing on clocks without sample_clk_ce.
REQ-030 SHALL, in DWELL on sample_clk_ce while the dwell count is below max(dwell,1)-1, increment the dwell count.
REQ-031 SHALL, in DWELL on sample_clk_ce at the last dwell sample with step_index below num_steps, clear the dwell count, update phase_increment to phase_increment+step modulo 2^PHASE_WIDTH, and increment step_index.
REQ-032 SHALL, on the last dwell sample with step_index equal to num_steps and cfg_loop=1, reload start_inc and clear step_index.
REQ-033 SHALL, on the last dwell sample with step_index equal to num_steps and cfg_loop=0, enter DONE.
REQ-034 SHALL make phase_increment and step_index updates visible the clk after the qualifying sample_clk_ce.
REQ-035 SHALL assert done for exactly one clk, the first clk in DONE; DONE then moves to IDLE unless start is high.
REQ-036 SHALL hold the last tuning word in phase_increment in DONE and IDLE.
REQ-037 SHALL, with num_steps=0, emit a single tone for max(dwell,1) samples and then finish.
REQ-038 SHALL, on abort in DWELL, take priority over stepping and start: go to IDLE on the next clk, clear phase_increment to 0, and give no done pulse.
REQ-039 SHALL ignore abort outside DWELL.

Reset
REQ-040 SHALL, while arst is high, hold the state at IDLE, the divider count and shadow registers at 0, and the outputs at phase_increment=0, step_index=0, sample_clk_ce=0, busy=0, done=0, cfg_ready=1.
REQ-041 SHALL abandon a sweep when arst is asserted mid-sweep, without a done pulse.

Structure
REQ-042 SHALL take the state enum and the default width constants from the shared package nco_ctrl_pkg.
REQ-043 SHALL place the strobe divider in one sub-module, sample_ce_divider.

Verification
REQ-044 SHALL verify a basic sweep: ce_div=1, start_inc=0x100, step=0x10, num_steps=3, dwell=2, loop=0, start -> phase_increment 0x100, 0x110, 0x120, 0x130, each held 4 clks; done pulses once after the 8th strobe; busy low afterwards.
REQ-045 SHALL verify negative-step wrap: start_inc=0x8, step=-0x10, num_steps=1, dwell=1, ce_div=0 -> second word 0xFFFFFFFFFFFFFFF8.
REQ-046 SHALL verify loop mode: the basic-sweep config with loop=1 -> after 0x130 the word returns to 0x100 with step_index=0 and done never pulses.
REQ-047 SHALL verify abort: abort at step_index=2 -> state IDLE and phase_increment=0 the next clk, no done pulse.
REQ-048 SHALL verify config gating: cfg_valid with new values during DWELL -> cfg_ready=0 and the running sweep is unchanged.
REQ-049 SHALL verify reset mid-sweep: arst pulsed at step 1 -> all outputs 0, cfg_ready=1, and after release the strobe period equals ce_div+1.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the NCO sweep controller.
// Imported by the divider, the config interface and the top level.
package nco_ctrl_pkg;

    localparam int PHASE_W_DEF  = 64;
    localparam int COUNT_W_DEF  = 16;
    localparam int DWELL_W_DEF  = 16;
    localparam int CE_DIV_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/nco_sweep_controller_if.sv
// Sweep configuration handshake: valid/ready plus the sweep parameters.
// The master offers a configuration, the controller accepts it when idle.
interface nco_sweep_controller_if
    import nco_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_W_DEF,
    parameter int COUNT_WIDTH = COUNT_W_DEF,
    parameter int DWELL_WIDTH = DWELL_W_DEF
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [PHASE_WIDTH-1:0] cfg_start_inc;
    logic [PHASE_WIDTH-1:0] cfg_step;
    logic [COUNT_WIDTH-1:0] cfg_num_steps;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic                   cfg_loop;

    modport master (
        output cfg_valid,
        output cfg_start_inc,
        output cfg_step,
        output cfg_num_steps,
        output cfg_dwell,
        output cfg_loop,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_start_inc,
        input  cfg_step,
        input  cfg_num_steps,
        input  cfg_dwell,
        input  cfg_loop,
        output cfg_ready
    );

endinterface

// File: rtl/sample_ce_divider.sv
// Free-running sample strobe divider: one-clk strobe every i_div+1 clocks.
// The strobe is registered so it stays low while arst is held.
module sample_ce_divider
    import nco_ctrl_pkg::*;
#(
    parameter int W = CE_DIV_W_DEF
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [W-1:0] i_div,
    output logic         o_ce
);
    logic [W-1:0] r_cnt;
    logic         r_ce;

    // count up to i_div, strobe on the match and wrap to zero
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_ce  <= (r_cnt == i_div);
            r_cnt <= (r_cnt >= i_div) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_ce = r_ce;

endmodule

// File: rtl/nco_sweep_controller.sv
// Frequency sweep controller: steps an NCO tuning word on sample strobes.
// Config is shadowed when idle; abort and arst drop the sweep without done.
module nco_sweep_controller
    import nco_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH  = PHASE_W_DEF,
    parameter int COUNT_WIDTH  = COUNT_W_DEF,
    parameter int DWELL_WIDTH  = DWELL_W_DEF,
    parameter int CE_DIV_WIDTH = CE_DIV_W_DEF
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [CE_DIV_WIDTH-1:0] ce_div,
    nco_sweep_controller_if.slave   cfg,
    input  logic                    start,
    input  logic                    abort,
    output logic                    sample_clk_ce,
    output logic [PHASE_WIDTH-1:0]  phase_increment,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_WIDTH-1:0]  step_index
);
    state_t r_state;
    state_t w_state_nxt;

    logic [PHASE_WIDTH-1:0] r_start_inc;
    logic [PHASE_WIDTH-1:0] r_step;
    logic [COUNT_WIDTH-1:0] r_num_steps;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_loop;

    logic [PHASE_WIDTH-1:0] r_phase;
    logic [COUNT_WIDTH-1:0] r_idx;
    logic [DWELL_WIDTH-1:0] r_dcnt;

    logic [PHASE_WIDTH-1:0] w_phase_nxt;
    logic [COUNT_WIDTH-1:0] w_idx_nxt;
    logic [DWELL_WIDTH-1:0] w_dcnt_nxt;

    logic                   w_ce;
    logic                   w_ready;
    logic                   w_xfer;
    logic [PHASE_WIDTH-1:0] w_eff_start;
    logic [DWELL_WIDTH-1:0] w_dwell_last;
    logic                   w_last;

    sample_ce_divider #(
        .W (CE_DIV_WIDTH)
    ) u_div (
        .clk   (clk),
        .arst  (arst),
        .i_div (ce_div),
        .o_ce  (w_ce)
    );

    assign w_ready       = (r_state != ST_DWELL);
    assign cfg.cfg_ready = w_ready;
    assign w_xfer        = cfg.cfg_valid & w_ready;

    // a transfer in the start clk must win over the old shadow value
    assign w_eff_start = w_xfer ? cfg.cfg_start_inc : r_start_inc;

    // dwell of 0 behaves as 1, so the last sample index is max(dwell,1)-1
    assign w_dwell_last = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
    assign w_last       = (r_dcnt >= w_dwell_last);

    // shadow registers capture an accepted configuration
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_start_inc <= '0;
            r_step      <= '0;
            r_num_steps <= '0;
            r_dwell     <= '0;
            r_loop      <= 1'b0;
        end else if (w_xfer) begin
            r_start_inc <= cfg.cfg_start_inc;
            r_step      <= cfg.cfg_step;
            r_num_steps <= cfg.cfg_num_steps;
            r_dwell     <= cfg.cfg_dwell;
            r_loop      <= cfg.cfg_loop;
        end
    end

    // state and sweep datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_idx   <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_idx   <= w_idx_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // next state and datapath: abort beats stepping, steps only on strobes
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        w_dcnt_nxt  = r_dcnt;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_DWELL;
                    w_phase_nxt = w_eff_start;
                    w_idx_nxt   = '0;
                    w_dcnt_nxt  = '0;
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                end else if (w_ce) begin
                    if (!w_last) begin
                        w_dcnt_nxt = r_dcnt + 1'b1;
                    end else if (r_idx < r_num_steps) begin
                        w_dcnt_nxt  = '0;
                        w_phase_nxt = r_phase + r_step;
                        w_idx_nxt   = r_idx + 1'b1;
                    end else if (r_loop) begin
                        w_dcnt_nxt  = '0;
                        w_phase_nxt = r_start_inc;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sample_clk_ce   = w_ce;
    assign phase_increment = r_phase;
    assign step_index      = r_idx;
    assign busy            = (r_state == ST_DWELL);
    assign done            = (r_state == ST_DONE);

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Directed bench for nco_sweep_controller with a tuning-word scoreboard.
// Expected words are queued at launch and popped as the DUT shows them.
module tb_nco_sweep_controller;
    import nco_ctrl_pkg::*;

    localparam int PW = 64;
    localparam int CW = 16;
    localparam int DW = 16;
    localparam int EW = 8;

    typedef struct {
        logic [PW-1:0] ph;
        logic [CW-1:0] idx;
        int            hold;
    } exp_t;

    logic          clk;
    logic          arst;
    logic [EW-1:0] ce_div;
    logic          start;
    logic          abort;
    logic          sample_clk_ce;
    logic [PW-1:0] phase_increment;
    logic          busy;
    logic          done;
    logic [CW-1:0] step_index;

    nco_sweep_controller_if #(
        .PHASE_WIDTH (PW),
        .COUNT_WIDTH (CW),
        .DWELL_WIDTH (DW)
    ) cfg_if ();

    nco_sweep_controller #(
        .PHASE_WIDTH  (PW),
        .COUNT_WIDTH  (CW),
        .DWELL_WIDTH  (DW),
        .CE_DIV_WIDTH (EW)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .ce_div          (ce_div),
        .cfg             (cfg_if.slave),
        .start           (start),
        .abort           (abort),
        .sample_clk_ce   (sample_clk_ce),
        .phase_increment (phase_increment),
        .busy            (busy),
        .done            (done),
        .step_index      (step_index)
    );

    int   checks = 0;
    int   fails  = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    bit            prev_busy = 1'b0;
    logic [PW-1:0] prev_phase = '0;
    int            run = 0;
    int            cur_hold = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] obs,
                       input logic [PW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [PW-1:0] ph, input logic [CW-1:0] idx,
                        input int hold);
        exp_t e;
        e.ph   = ph;
        e.idx  = idx;
        e.hold = hold;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input logic [PW-1:0] s, input logic [PW-1:0] st,
                           input logic [CW-1:0] n, input logic [DW-1:0] d,
                           input logic lp);
        cfg_if.cfg_start_inc = s;
        cfg_if.cfg_step      = st;
        cfg_if.cfg_num_steps = n;
        cfg_if.cfg_dwell     = d;
        cfg_if.cfg_loop      = lp;
    endtask

    // start right after a strobe so every word gets a full dwell
    task automatic launch(input bit with_cfg, input bit align);
        if (align) begin
            for (int i = 0; i < 50 && sample_clk_ce !== 1'b1; i++)
                @(negedge clk);
            chk("launch_align", sample_clk_ce, 1'b1);
        end
        start = 1'b1;
        cfg_if.cfg_valid = with_cfg;
        @(negedge clk);
        start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 400 && done_cnt == d0; i++)
            @(negedge clk);
        chk(tag, done_cnt, d0 + 1);
    endtask

    // scoreboard monitor: each new word is popped and its hold time checked
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1)
            done_cnt++;
        if (busy === 1'b1) begin
            if (prev_busy && phase_increment === prev_phase) begin
                run++;
            end else begin
                if (prev_busy && cur_hold != 0)
                    chk("hold", run, cur_hold);
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", exp_q.size(), 1);
                    cur_hold = 0;
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_phase", phase_increment, e.ph);
                    chk("sb_index", step_index, e.idx);
                    cur_hold = e.hold;
                end
                run = 1;
            end
        end else if (prev_busy) begin
            if (cur_hold != 0)
                chk("hold_last", run, cur_hold);
            cur_hold = 0;
        end
        prev_busy  = (busy === 1'b1);
        prev_phase = phase_increment;
    end

    initial begin
        int d0;
        int n;
        arst   = 1'b1;
        ce_div = 8'd1;
        start  = 1'b0;
        abort  = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_phase", phase_increment, '0);
        chk("rst_index", step_index, '0);
        chk("rst_ce", sample_clk_ce, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", cfg_if.cfg_ready, 1'b1);
        arst = 1'b0;
        repeat (4) @(negedge clk);

        // basic sweep
        d0 = done_cnt;
        set_cfg(64'h100, 64'h10, 16'd3, 16'd2, 1'b0);
        push(64'h100, 16'd0, 4);
        push(64'h110, 16'd1, 4);
        push(64'h120, 16'd2, 4);
        push(64'h130, 16'd3, 4);
        launch(1'b1, 1'b1);
        wait_done("basic_done", d0);
        @(negedge clk);
        chk("basic_busy_after", busy, 1'b0);
        chk("basic_hold_word", phase_increment, 64'h130);
        chk("basic_done_once", done_cnt, d0 + 1);
        chk("basic_drain", exp_q.size(), 0);

        // negative step wraps modulo 2^64
        ce_div = 8'd0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        set_cfg(64'h8, 64'hFFFF_FFFF_FFFF_FFF0, 16'd1, 16'd1, 1'b0);
        push(64'h8, 16'd0, 1);
        push(64'hFFFF_FFFF_FFFF_FFF8, 16'd1, 1);
        launch(1'b1, 1'b0);
        wait_done("wrap_done", d0);
        chk("wrap_drain", exp_q.size(), 0);

        // zero steps and zero dwell: single tone for one sample
        ce_div = 8'd2;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        set_cfg(64'h55, 64'h1, 16'd0, 16'd0, 1'b0);
        push(64'h55, 16'd0, 0);
        launch(1'b1, 1'b0);
        wait_done("single_done", d0);
        chk("single_drain", exp_q.size(), 0);

        // loop mode returns to start_inc, no done
        ce_div = 8'd1;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        set_cfg(64'h100, 64'h10, 16'd3, 16'd2, 1'b1);
        push(64'h100, 16'd0, 4);
        push(64'h110, 16'd1, 4);
        push(64'h120, 16'd2, 4);
        push(64'h130, 16'd3, 4);
        push(64'h100, 16'd0, 4);
        push(64'h110, 16'd1, 0);
        launch(1'b1, 1'b1);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++)
            @(negedge clk);
        chk("loop_drain", exp_q.size(), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("loop_abort_busy", busy, 1'b0);
        chk("loop_abort_phase", phase_increment, '0);
        chk("loop_no_done", done_cnt, d0);

        // abort at step 2
        d0 = done_cnt;
        set_cfg(64'h100, 64'h10, 16'd3, 16'd2, 1'b0);
        push(64'h100, 16'd0, 4);
        push(64'h110, 16'd1, 4);
        push(64'h120, 16'd2, 0);
        launch(1'b1, 1'b1);
        for (int i = 0; i < 200 && step_index !== 16'd2; i++)
            @(negedge clk);
        chk("abort_reach_idx2", step_index, 16'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_phase", phase_increment, '0);
        chk("abort_ready", cfg_if.cfg_ready, 1'b1);
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_drain", exp_q.size(), 0);

        // abort outside DWELL is ignored
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_busy", busy, 1'b0);

        // config offered during DWELL is refused
        d0 = done_cnt;
        set_cfg(64'h100, 64'h10, 16'd3, 16'd2, 1'b0);
        push(64'h100, 16'd0, 4);
        push(64'h110, 16'd1, 4);
        push(64'h120, 16'd2, 4);
        push(64'h130, 16'd3, 4);
        launch(1'b1, 1'b1);
        @(negedge clk);
        set_cfg(64'hABC, 64'h1, 16'd9, 16'd7, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        @(negedge clk);
        chk("gate_ready_low", cfg_if.cfg_ready, 1'b0);
        repeat (2) @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        wait_done("gate_done", d0);
        chk("gate_drain", exp_q.size(), 0);
        // rerun from the shadow: must still be the original sweep
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        push(64'h100, 16'd0, 4);
        push(64'h110, 16'd1, 4);
        push(64'h120, 16'd2, 4);
        push(64'h130, 16'd3, 4);
        launch(1'b0, 1'b1);
        wait_done("gate_rerun_done", d0);
        chk("gate_rerun_drain", exp_q.size(), 0);

        // arst mid-sweep
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        push(64'h100, 16'd0, 4);
        push(64'h110, 16'd1, 0);
        launch(1'b0, 1'b1);
        for (int i = 0; i < 200 && step_index !== 16'd1; i++)
            @(negedge clk);
        chk("rst_reach_idx1", step_index, 16'd1);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("mrst_phase", phase_increment, '0);
        chk("mrst_index", step_index, '0);
        chk("mrst_ce", sample_clk_ce, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_ready", cfg_if.cfg_ready, 1'b1);
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 20 && sample_clk_ce !== 1'b1; i++)
            @(negedge clk);
        chk("mrst_ce_seen", sample_clk_ce, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (sample_clk_ce === 1'b1)
                break;
        end
        chk("mrst_ce_period", n, 2);
        chk("mrst_no_done", done_cnt, d0);
        chk("mrst_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
